// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the IF/MEM single-port bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_BUS = 32;
    localparam int unsigned DATA_BUS = 32;
    localparam int unsigned SEL_W    = 4;

    localparam logic [SEL_W-1:0] IF_SEL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts BUSY cycles without bus_ready and flags expiry on the TIMEOUT-th one.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero TIMEOUT disables expiry entirely.
    assign expire_c = (TIMEOUT != 0) && enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter: MEM has fixed priority over IF, one access per IDLE->BUSY->DONE pass.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_BUS,
    parameter int unsigned DATA_W  = DATA_BUS,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              bus_en,
    output logic              bus_write_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [SEL_W-1:0]  bus_sel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              stall_req_if,
    output logic              stall_req_mem,
    output logic              bus_err
);

    state_e            state_q, state_d;
    logic              bus_en_q, bus_en_d;
    logic              bus_write_en_q, bus_write_en_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic              bus_err_q, bus_err_d;

    logic busy;
    logic wd_expire_c;

    assign busy = (state_q == ST_IF_BUSY) || (state_q == ST_MEM_BUSY);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (~busy),
        .enable   (busy & ~bus_ready),
        .expire_c (wd_expire_c)
    );

    // Next state and datapath; bus_ready takes precedence over a same-cycle expiry.
    always_comb begin
        state_d        = state_q;
        bus_en_d       = bus_en_q;
        bus_write_en_d = bus_write_en_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        bus_sel_d      = bus_sel_q;
        if_rdata_d     = if_rdata_q;
        mem_rdata_d    = mem_rdata_q;
        if_done_d      = 1'b0;
        mem_done_d     = 1'b0;
        bus_err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d        = ST_MEM_BUSY;
                    bus_en_d       = 1'b1;
                    bus_write_en_d = mem_write_en;
                    bus_addr_d     = mem_addr;
                    bus_wdata_d    = mem_wdata;
                    bus_sel_d      = mem_sel;
                end else if (if_req) begin
                    state_d        = ST_IF_BUSY;
                    bus_en_d       = 1'b1;
                    bus_write_en_d = 1'b0;
                    bus_addr_d     = if_addr;
                    bus_wdata_d    = '0;
                    bus_sel_d      = IF_SEL;
                end
            end
            ST_IF_BUSY, ST_MEM_BUSY: begin
                if (bus_ready) begin
                    state_d  = ST_DONE;
                    bus_en_d = 1'b0;
                    if (state_q == ST_MEM_BUSY) begin
                        mem_done_d = 1'b1;
                        if (!bus_write_en_q) begin
                            mem_rdata_d = bus_rdata;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else if (wd_expire_c) begin
                    state_d   = ST_DONE;
                    bus_en_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == ST_MEM_BUSY) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                bus_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bus_en_q       <= 1'b0;
            bus_write_en_q <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_sel_q      <= '0;
            if_rdata_q     <= '0;
            mem_rdata_q    <= '0;
            if_done_q      <= 1'b0;
            mem_done_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus_en_q       <= bus_en_d;
            bus_write_en_q <= bus_write_en_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            bus_sel_q      <= bus_sel_d;
            if_rdata_q     <= if_rdata_d;
            mem_rdata_q    <= mem_rdata_d;
            if_done_q      <= if_done_d;
            mem_done_q     <= mem_done_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign bus_en       = bus_en_q;
    assign bus_write_en = bus_write_en_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_sel      = bus_sel_q;
    assign if_rdata     = if_rdata_q;
    assign mem_rdata    = mem_rdata_q;
    assign if_done      = if_done_q;
    assign mem_done     = mem_done_q;
    assign bus_err      = bus_err_q;

    // Each stage stays stalled until its own done pulse.
    assign stall_req_mem = mem_req & ~mem_done_q;
    assign stall_req_if  = if_req & ~if_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two instances (TIMEOUT 255 and 4) against a transaction-level model.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        bus_en;
        logic        bus_write_en;
        logic [31:0] bus_addr;
        logic [31:0] bus_wdata;
        logic [3:0]  bus_sel;
        logic [31:0] if_rdata;
        logic [31:0] mem_rdata;
        logic        if_done;
        logic        mem_done;
        logic        bus_err;
        logic        stall_if;
        logic        stall_mem;
    } obs_t;

    localparam int unsigned TO_VAL [2] = '{255, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    logic [31:0] w_if_rdata     [2];
    logic        w_if_done      [2];
    logic [31:0] w_mem_rdata    [2];
    logic        w_mem_done     [2];
    logic        w_bus_en       [2];
    logic        w_bus_write_en [2];
    logic [31:0] w_bus_addr     [2];
    logic [31:0] w_bus_wdata    [2];
    logic [3:0]  w_bus_sel      [2];
    logic        w_stall_if     [2];
    logic        w_stall_mem    [2];
    logic        w_bus_err      [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cnt [2] = '{0, 0};
    logic prev_en [2] = '{1'b0, 1'b0};

    // Model of the access each instance is carrying: 0 = no access, 1 = on the bus, 2 = completion cycle.
    int   m_phase [2] = '{0, 0};
    int   m_wait  [2] = '{0, 0};
    logic m_mem   [2] = '{1'b0, 1'b0};
    obs_t m_out   [2] = '{'0, '0};

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(w_if_rdata[0]), .if_done(w_if_done[0]),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(w_mem_rdata[0]), .mem_done(w_mem_done[0]),
        .bus_en(w_bus_en[0]), .bus_write_en(w_bus_write_en[0]), .bus_addr(w_bus_addr[0]),
        .bus_wdata(w_bus_wdata[0]), .bus_sel(w_bus_sel[0]), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .stall_req_if(w_stall_if[0]), .stall_req_mem(w_stall_mem[0]), .bus_err(w_bus_err[0])
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(w_if_rdata[1]), .if_done(w_if_done[1]),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(w_mem_rdata[1]), .mem_done(w_mem_done[1]),
        .bus_en(w_bus_en[1]), .bus_write_en(w_bus_write_en[1]), .bus_addr(w_bus_addr[1]),
        .bus_wdata(w_bus_wdata[1]), .bus_sel(w_bus_sel[1]), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .stall_req_if(w_stall_if[1]), .stall_req_mem(w_stall_mem[1]), .bus_err(w_bus_err[1])
    );

    function automatic obs_t actual(input int i);
        obs_t o;
        o.bus_en       = w_bus_en[i];
        o.bus_write_en = w_bus_write_en[i];
        o.bus_addr     = w_bus_addr[i];
        o.bus_wdata    = w_bus_wdata[i];
        o.bus_sel      = w_bus_sel[i];
        o.if_rdata     = w_if_rdata[i];
        o.mem_rdata    = w_mem_rdata[i];
        o.if_done      = w_if_done[i];
        o.mem_done     = w_mem_done[i];
        o.bus_err      = w_bus_err[i];
        o.stall_if     = w_stall_if[i];
        o.stall_mem    = w_stall_mem[i];
        return o;
    endfunction

    // Advance the model by one clock edge, using the inputs the DUT sampled at that edge.
    task automatic model_step(input int i);
        m_out[i].if_done  = 1'b0;
        m_out[i].mem_done = 1'b0;
        m_out[i].bus_err  = 1'b0;
        if (rst) begin
            m_out[i] = '0;
            m_phase[i] = 0;
            m_wait[i] = 0;
        end else if (m_phase[i] == 0) begin
            if (mem_req || if_req) begin
                m_mem[i] = mem_req;
                m_phase[i] = 1;
                m_wait[i] = 0;
                m_out[i].bus_en       = 1'b1;
                m_out[i].bus_write_en = mem_req ? mem_write_en : 1'b0;
                m_out[i].bus_addr     = mem_req ? mem_addr : if_addr;
                m_out[i].bus_wdata    = mem_req ? mem_wdata : 32'h0;
                m_out[i].bus_sel      = mem_req ? mem_sel : 4'hF;
            end
        end else if (m_phase[i] == 1) begin
            if (!bus_ready) m_wait[i] = m_wait[i] + 1;
            if (bus_ready || (TO_VAL[i] != 0 && m_wait[i] >= int'(TO_VAL[i]))) begin
                m_phase[i] = 2;
                m_out[i].bus_en  = 1'b0;
                m_out[i].bus_err = !bus_ready;
                if (m_mem[i]) begin
                    m_out[i].mem_done = 1'b1;
                    if (!bus_ready) m_out[i].mem_rdata = 32'h0;
                    else if (!m_out[i].bus_write_en) m_out[i].mem_rdata = bus_rdata;
                end else begin
                    m_out[i].if_done  = 1'b1;
                    m_out[i].if_rdata = bus_ready ? bus_rdata : 32'h0;
                end
            end
        end else begin
            m_phase[i] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors = vectors + 1;
        if (got !== want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Per-cycle compare of every output against the model, shortly after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) model_step(i);
            #2;
            for (int i = 0; i < 2; i++) begin
                obs_t e;
                obs_t a;
                e = m_out[i];
                e.stall_if  = if_req & ~e.if_done;
                e.stall_mem = mem_req & ~e.mem_done;
                a = actual(i);
                vectors = vectors + 1;
                if (a !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL outputs dut%0d cyc=%0d got=%h want=%h", i, cyc, a, e);
                end
                if (a.bus_en === 1'b1 && prev_en[i] !== 1'b1) acc_cnt[i] = acc_cnt[i] + 1;
                prev_en[i] = a.bus_en;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; mem_req = 1'b0; mem_write_en = 1'b0; bus_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle_inputs();
        if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_sel = '0; bus_rdata = '0;
        step(); step();
        chk("rst_bus_en", 32'(w_bus_en[0]), 32'h0);
        chk("rst_bus_addr", w_bus_addr[0], 32'h0);
        chk("rst_rdata", w_if_rdata[0] | w_mem_rdata[0], 32'h0);
        chk("rst_done_err", 32'({w_if_done[0], w_mem_done[0], w_bus_err[0]}), 32'h0);
        rst = 1'b0;
        step();

        // IF only, ready on the first BUSY cycle.
        if_req = 1'b1; if_addr = 32'h0000_0040; bus_ready = 1'b1; bus_rdata = 32'h2402_0005;
        step();
        chk("if_bus_en", 32'(w_bus_en[0]), 32'h1);
        chk("if_bus_sel", 32'(w_bus_sel[0]), 32'hF);
        step();
        chk("if_done", 32'(w_if_done[0]), 32'h1);
        chk("if_rdata", w_if_rdata[0], 32'h2402_0005);
        chk("if_stall_low", 32'(w_stall_if[0]), 32'h0);
        idle_inputs();
        step(); step();

        // Simultaneous requests: MEM first, IF in the IDLE after mem_done.
        mem_req = 1'b1; mem_addr = 32'h8000_1000; mem_sel = 4'hF; mem_wdata = '0;
        if_req = 1'b1; if_addr = 32'h0000_0044; bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
        step();
        chk("pri_bus_addr", w_bus_addr[0], 32'h8000_1000);
        chk("pri_stall_if", 32'(w_stall_if[0]), 32'h1);
        step();
        chk("pri_mem_done", 32'(w_mem_done[0]), 32'h1);
        chk("pri_mem_rdata", w_mem_rdata[0], 32'h1111_2222);
        chk("pri_stall_if2", 32'(w_stall_if[0]), 32'h1);
        mem_req = 1'b0; bus_rdata = 32'h3333_4444;
        step();
        chk("pri_gap_bus_en", 32'(w_bus_en[0]), 32'h0);
        step();
        chk("pri_if_addr", w_bus_addr[0], 32'h0000_0044);
        step();
        chk("pri_if_rdata", w_if_rdata[0], 32'h3333_4444);
        idle_inputs();
        step(); step();

        // Store with ready on the 5th BUSY cycle; the TIMEOUT=4 instance expires first.
        mem_req = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h0000_0010;
        mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011; bus_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("st_bus_en", 32'(w_bus_en[0]), 32'h1);
            chk("st_bus_hold", w_bus_addr[0] ^ w_bus_wdata[0], 32'hDEAD_BEFF);
            chk("st_bus_sel_we", 32'({w_bus_write_en[0], w_bus_sel[0]}), 32'h13);
        end
        chk("st_to_err", 32'(w_bus_err[1]), 32'h1);
        bus_ready = 1'b1;
        step();
        chk("st_mem_done", 32'(w_mem_done[0]), 32'h1);
        chk("st_mem_rdata_kept", w_mem_rdata[0], 32'h1111_2222);
        chk("st_to_rdata", w_mem_rdata[1], 32'h0);
        idle_inputs();
        step(); step();

        // Load with no ready: TIMEOUT=4 instance aborts after 4 BUSY cycles.
        mem_req = 1'b1; mem_addr = 32'h0000_0020; mem_sel = 4'hF; bus_rdata = 32'hCAFE_F00D;
        for (int k = 1; k <= 4; k++) step();
        chk("to_no_err_yet", 32'(w_bus_err[1]), 32'h0);
        step();
        chk("to_err_done", 32'({w_bus_err[1], w_mem_done[1]}), 32'h3);
        chk("to_rdata_zero", w_mem_rdata[1], 32'h0);
        chk("to_long_busy", 32'(w_bus_en[0]), 32'h1);
        mem_req = 1'b0; bus_ready = 1'b1;
        step();
        chk("to_long_rdata", w_mem_rdata[0], 32'hCAFE_F00D);
        chk("to_idle_err", 32'({w_bus_err[1], w_bus_en[1]}), 32'h0);
        idle_inputs();
        step(); step();

        // Reset during the 2nd BUSY cycle abandons the fetch.
        if_req = 1'b1; if_addr = 32'h0000_0048; bus_rdata = 32'h5555_AAAA;
        step(); step();
        chk("rstmid_busy", 32'(w_bus_en[0]), 32'h1);
        rst = 1'b1;
        step();
        chk("rstmid_bus_en", 32'(w_bus_en[0]), 32'h0);
        chk("rstmid_no_done", 32'(w_if_done[0]), 32'h0);
        rst = 1'b0; bus_ready = 1'b1;
        step();
        chk("rstmid_reissue", w_bus_addr[0], 32'h0000_0048);
        step();
        chk("rstmid_rdata", w_if_rdata[0], 32'h5555_AAAA);
        idle_inputs();
        step(); step();

        // mem_req held through DONE: still a single bus access.
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        mem_req = 1'b1; mem_addr = 32'h0000_0030; bus_ready = 1'b1; bus_rdata = 32'h0BAD_CAFE;
        step(); step();
        chk("hold_done", 32'(w_mem_done[0]), 32'h1);
        step();
        chk("hold_gap", 32'(w_bus_en[0]), 32'h0);
        mem_req = 1'b0;
        step(); step();
        chk("hold_acc0", 32'(acc_cnt[0]), 32'h1);
        chk("hold_acc1", 32'(acc_cnt[1]), 32'h1);
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
